// File: rtl/lcd_pkg.sv
// Shared FSM states, instruction-bit positions and AC stepping for the LCD bus responder.
package lcd_pkg;

    typedef enum logic [2:0] {IDLE, EXEC, CLEAR_FILL, INIT_FILL, BUSY} state_t;

    // Leading-one positions of the instruction byte.
    localparam int B_SET_DDRAM = 7;
    localparam int B_SET_CGRAM = 6;
    localparam int B_FUNC      = 5;
    localparam int B_SHIFT     = 4;
    localparam int B_DISP      = 3;
    localparam int B_ENTRY     = 2;
    localparam int B_HOME      = 1;
    localparam int B_CLEAR     = 0;

    // Argument bits inside the instructions.
    localparam int B_DL = 4;
    localparam int B_SC = 3;
    localparam int B_RL = 2;
    localparam int B_ID = 1;
    localparam int B_SH = 0;

    localparam logic [7:0] LCD_SPACE = 8'h20;

    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc, input int depth);
        if (inc) return (int'(ac) >= depth - 1) ? 7'd0 : ac + 7'd1;
        return (ac == 7'd0) ? 7'(depth - 1) : ac - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// Character RAM: read/write port for the FSM, independent synchronous read port for debug.
module lcd_ddram #(
    parameter int DEPTH = 80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_a_we,
    input  logic [6:0] i_a_addr,
    input  logic [7:0] i_a_wdata,
    output logic [7:0] o_a_rdata,
    input  logic [6:0] i_b_addr,
    output logic [7:0] o_b_rdata
);
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_a_q, r_b_q;
    logic       w_a_ok, w_b_ok;

    assign w_a_ok = int'(i_a_addr) < DEPTH;
    assign w_b_ok = int'(i_b_addr) < DEPTH;

    always_ff @(posedge clk) begin
        if (i_a_we && w_a_ok) r_mem[i_a_addr] <= i_a_wdata;
    end

    // Reads sample the array before this cycle's write lands (read-old).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_q <= '0;
            r_b_q <= '0;
        end else begin
            r_a_q <= w_a_ok ? r_mem[i_a_addr] : '0;
            r_b_q <= w_b_ok ? r_mem[i_b_addr] : '0;
        end
    end

    assign o_a_rdata = r_a_q;
    assign o_b_rdata = r_b_q;
endmodule

// File: rtl/lcd_bus_responder.sv
// Display-side HD44780 responder: samples the controller's E/RS/RW/DB bus, executes
// instructions and data writes into a DDRAM image, and answers BF/AC and data reads.
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int DDRAM_DEPTH = 80,
    parameter int BUSY_SHORT  = 2000,
    parameter int BUSY_LONG   = 76500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       e,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       busy,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       entry_shift,
    output logic       func_8bit,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic       protocol_err
);
    localparam int         CNT_W     = $clog2(BUSY_LONG + 1);
    localparam logic [6:0] LAST_CELL = 7'(DDRAM_DEPTH - 1);

    logic [1:0]       r_e_sync, r_rs_sync, r_rw_sync;
    logic [7:0]       r_db_s1, r_db_s2;
    logic             r_e_d, r_rise_d;
    logic             r_cap_rs, r_cap_rw;
    logic [7:0]       r_cap_db;

    state_t           r_state, w_next;
    logic [6:0]       r_ac, r_fill_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy, r_perr;
    logic             r_disp, r_cursor, r_blink, r_inc, r_shift, r_dl;
    logic [7:0]       r_cmd, r_prefetch;
    logic             r_cmd_rs;

    logic       w_e, w_rs, w_rw, w_rise, w_fall;
    logic       w_wr_fall, w_wr_ok, w_rd_fall, w_fill, w_fill_last;
    logic       w_is_clear, w_is_home, w_ram_we;
    logic [6:0] w_ram_addr;
    logic [7:0] w_ram_wd, w_ram_q;

    assign w_e    = r_e_sync[1];
    assign w_rs   = r_rs_sync[1];
    assign w_rw   = r_rw_sync[1];
    assign w_rise = w_e & ~r_e_d;
    assign w_fall = ~w_e & r_e_d;

    // A bus cycle's rs/rw/data are whatever was last seen while E was high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e_sync  <= '0;
            r_rs_sync <= '0;
            r_rw_sync <= '0;
            r_db_s1   <= '0;
            r_db_s2   <= '0;
            r_e_d     <= 1'b0;
            r_rise_d  <= 1'b0;
            r_cap_rs  <= 1'b0;
            r_cap_rw  <= 1'b0;
            r_cap_db  <= '0;
        end else begin
            r_e_sync  <= {r_e_sync[0], e};
            r_rs_sync <= {r_rs_sync[0], rs};
            r_rw_sync <= {r_rw_sync[0], rw};
            r_db_s1   <= lcd_data_in;
            r_db_s2   <= r_db_s1;
            r_e_d     <= w_e;
            r_rise_d  <= w_rise;
            if (w_e) begin
                r_cap_rs <= w_rs;
                r_cap_rw <= w_rw;
                r_cap_db <= r_db_s2;
            end
        end
    end

    assign w_wr_fall   = w_fall & ~r_cap_rw;
    assign w_wr_ok     = w_wr_fall & (r_state == IDLE) & ~r_busy;
    assign w_rd_fall   = w_fall & r_cap_rw & r_cap_rs;
    assign w_fill      = (r_state == CLEAR_FILL) || (r_state == INIT_FILL);
    assign w_fill_last = (r_fill_idx == LAST_CELL);
    assign w_is_clear  = ~r_cmd_rs & (r_cmd == 8'h01);
    assign w_is_home   = ~r_cmd_rs & (r_cmd[7:1] == 7'h01);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= INIT_FILL;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       if (w_wr_ok) w_next = EXEC;
            EXEC:       w_next = w_is_clear ? CLEAR_FILL : BUSY;
            CLEAR_FILL: if (w_fill_last) w_next = BUSY;
            INIT_FILL:  if (w_fill_last) w_next = IDLE;
            BUSY:       if (r_cnt == '0) w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ac       <= '0;
            r_fill_idx <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_perr     <= 1'b0;
            r_disp     <= 1'b0;
            r_cursor   <= 1'b0;
            r_blink    <= 1'b0;
            r_inc      <= 1'b1;
            r_shift    <= 1'b0;
            r_dl       <= 1'b1;
            r_cmd      <= '0;
            r_cmd_rs   <= 1'b0;
            r_prefetch <= '0;
        end else begin
            r_perr <= (w_wr_fall & ~w_wr_ok) | (w_rd_fall & r_busy);
            if (r_rise_d) r_prefetch <= w_ram_q;
            case (r_state)
                IDLE: begin
                    if (w_wr_ok) begin
                        r_cmd    <= r_cap_db;
                        r_cmd_rs <= r_cap_rs;
                        r_busy   <= 1'b1;
                    end else if (w_rd_fall && !r_busy) begin
                        r_ac <= ac_step(r_ac, r_inc, DDRAM_DEPTH);
                    end
                end
                EXEC: begin
                    // Clear/home busy time also covers the fill that follows.
                    r_cnt <= (w_is_clear || w_is_home) ? CNT_W'(BUSY_LONG) : CNT_W'(BUSY_SHORT);
                    if (r_cmd_rs)                  r_ac <= ac_step(r_ac, r_inc, DDRAM_DEPTH);
                    else if (r_cmd[B_SET_DDRAM])   r_ac <= (int'(r_cmd[6:0]) >= DDRAM_DEPTH) ? 7'd0 : r_cmd[6:0];
                    else if (r_cmd[B_SET_CGRAM]) begin
                    end
                    else if (r_cmd[B_FUNC])        r_dl <= r_cmd[B_DL];
                    else if (r_cmd[B_SHIFT]) begin
                        if (!r_cmd[B_SC]) r_ac <= ac_step(r_ac, r_cmd[B_RL], DDRAM_DEPTH);
                    end
                    else if (r_cmd[B_DISP])        {r_disp, r_cursor, r_blink} <= r_cmd[2:0];
                    else if (r_cmd[B_ENTRY]) begin
                        r_inc   <= r_cmd[B_ID];
                        r_shift <= r_cmd[B_SH];
                    end
                    else if (r_cmd[B_HOME])        r_ac <= '0;
                    else if (r_cmd[B_CLEAR]) begin
                        r_ac  <= '0;
                        r_inc <= 1'b1;
                    end
                end
                CLEAR_FILL, INIT_FILL: begin
                    r_fill_idx <= w_fill_last ? 7'd0 : r_fill_idx + 7'd1;
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                    if (r_state == INIT_FILL && w_fill_last) r_busy <= 1'b0;
                end
                BUSY: begin
                    if (r_cnt == '0) r_busy <= 1'b0;
                    else             r_cnt  <= r_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign w_ram_we   = w_fill | ((r_state == EXEC) & r_cmd_rs);
    assign w_ram_addr = w_fill ? r_fill_idx : r_ac;
    assign w_ram_wd   = w_fill ? LCD_SPACE : r_cmd;

    lcd_ddram #(.DEPTH(DDRAM_DEPTH)) u_ddram (
        .clk       (clk),
        .reset     (reset),
        .i_a_we    (w_ram_we),
        .i_a_addr  (w_ram_addr),
        .i_a_wdata (w_ram_wd),
        .o_a_rdata (w_ram_q),
        .i_b_addr  (rd_addr),
        .o_b_rdata (rd_data)
    );

    assign lcd_data_oe  = w_e & w_rw;
    assign lcd_data_out = lcd_data_oe ? (w_rs ? r_prefetch : {r_busy, r_ac}) : 8'h00;
    assign busy         = r_busy;
    assign disp_on      = r_disp;
    assign cursor_on    = r_cursor;
    assign blink_on     = r_blink;
    assign entry_inc    = r_inc;
    assign entry_shift  = r_shift;
    assign func_8bit    = r_dl;
    assign cmd_valid    = (r_state == EXEC);
    assign cmd_code     = r_cmd;
    assign protocol_err = r_perr;
endmodule

// File: doc/lcd_bus_responder.md
Name: lcd_bus_responder

Overview:
- Synthesizable HD44780-compatible responder: the display-side end of the 8-bit LCD bus that the display controller drives.
- Captures E/RS/RW/DB cycles, decodes instructions and data writes, keeps an 80-byte DDRAM image, and answers busy-flag/address and data reads.
- Used on-chip to mirror LCD contents to a debug port, and as a closed-loop target for controller bring-up without a physical panel.

Parameters:
- DDRAM_DEPTH, 80, number of DDRAM character cells; addresses 0..DDRAM_DEPTH-1.
- BUSY_SHORT, 2000, busy cycles after a normal instruction or data write (40 us at 50 MHz).
- BUSY_LONG, 76500, busy cycles after clear display or return home (1.53 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- e  in  1  LCD enable from the controller; asynchronous to clk.
- rs  in  1  register select: 0 = instruction, 1 = data.
- rw  in  1  0 = write, 1 = read.
- lcd_data_in  in  8  DB[7:0] driven by the controller.
- lcd_data_out  out  8  DB[7:0] returned on reads.
- lcd_data_oe  out  1  high while the responder drives DB.
- busy  out  1  busy flag (BF).
- disp_on, cursor_on, blink_on  out  1 each  display-control bits D, C, B.
- entry_inc, entry_shift  out  1 each  entry-mode bits I/D and S.
- func_8bit  out  1  function-set DL bit.
- rd_addr  in  7  debug read address into DDRAM.
- rd_data  out  8  DDRAM[rd_addr], one-cycle latency.
- cmd_valid  out  1  one-cycle pulse for each accepted write cycle.
- cmd_code  out  8  byte captured by the last accepted write.
- protocol_err  out  1  one-cycle pulse when a write cycle is rejected.

Behaviour:
- Reset values:
  - Outputs: lcd_data_out=0, lcd_data_oe=0, busy=1, disp_on=0, cursor_on=0, blink_on=0, entry_inc=1, entry_shift=0, func_8bit=1, cmd_valid=0, cmd_code=0, protocol_err=0, rd_data=0.
  - Internal: AC=0.
  - On reset release the block enters INIT_FILL.
- Input synchronisation and capture:
  - e, rs, rw and lcd_data_in pass through 2-flop synchronisers.
  - A falling edge of synced e ends a bus cycle. rs, rw and data are captured from the last synced sample with e=1.
  - An E pulse of a single sampled cycle is still a valid bus cycle.
- Read drive:
  - lcd_data_oe = synced e AND synced rw, combinational from the synced signals.
  - rs=0 read: lcd_data_out = {busy, AC[6:0]}. Allowed while busy.
  - rs=1 read: lcd_data_out = DDRAM[AC], prefetched when E rises. At the falling edge AC steps per entry_inc. Rejected while busy: protocol_err pulses and AC is unchanged.
- Write decode (rs=0, rw=0), by leading one of the byte; busy=BUSY_SHORT unless noted:
  - bit7 set DDRAM address: AC=data[6:0]; a value ≥ DDRAM_DEPTH loads 0.
  - bit6 set CGRAM address: no state change; cmd_valid still pulses.
  - bit5 function set: func_8bit=data[4].
  - bit4 cursor/display shift:
    - S/C=0: AC moves right (R/L=1) or left, with wrap.
    - S/C=1: display shift, no state change.
  - bit3 display control: disp_on, cursor_on, blink_on = data[2:0].
  - bit2 entry mode: entry_inc=data[1], entry_shift=data[0].
  - bit1 return home: AC=0; busy=BUSY_LONG.
  - bit0 clear display: enter CLEAR_FILL, AC=0, entry_inc=1; busy=BUSY_LONG.
  - 0x00: no-op, but still accepted.
- Data write (rs=1, rw=0): DDRAM[AC]=data, then AC steps per entry_inc.
- Address wrap: AC increments DDRAM_DEPTH-1 → 0 and decrements 0 → DDRAM_DEPTH-1.
- State machine:
  - IDLE → EXEC when a write cycle is captured and busy=0.
  - EXEC (1 cycle): apply the decode, pulse cmd_valid, load the busy counter → BUSY, or → CLEAR_FILL for clear display.
  - CLEAR_FILL / INIT_FILL: write 0x20 to one cell per cycle, DDRAM_DEPTH cycles, then → BUSY. INIT_FILL then sets busy=0 and goes to IDLE.
  - BUSY: counter decrements; busy=0 and → IDLE one cycle after it reaches 0. BUSY_LONG counts from fill start, so it covers the fill.
- Latency: a DDRAM write is visible on rd_data within 5 clk after raw e falls.
- Write cycle while busy (any state except IDLE): ignored, protocol_err pulses, busy timing unchanged.
- A debug read of an address the fill is writing in the same cycle returns the old value.
- Reset mid-operation: all state returns to reset values and INIT_FILL restarts.

Decomposition:
- Package lcd_pkg holds:
  - state_t enum {IDLE, EXEC, CLEAR_FILL, INIT_FILL, BUSY};
  - instruction bit-position constants;
  - LCD_SPACE = 8'h20.
- Sub-module lcd_ddram: DDRAM_DEPTH×8 dual-port RAM with one read/write port for the FSM and one synchronous read port for the debug read.

Test Plan:
- Reset, then poll an rs=0 read every 20 cycles → BF=1 for ≥80 cycles, then 0x00; every rd_data reads 0x20.
- Bus writes 0x38, 0x0E, 0x06, then data 0x48 ('H'), then 0x49 ('I'), each spaced > BUSY_SHORT → func_8bit=1; disp_on=1, cursor_on=1, blink_on=0; DDRAM[0]=0x48, DDRAM[1]=0x49; BF read returns 0x02.
- Write 0xCF (AC=0x4F), then data 0x41 → DDRAM[0x4F]=0x41 and AC wraps to 0x00. With entry mode 0x04, data write at AC=0 → AC=0x4F.
- Clear (0x01) followed by data 0x5A after 100 cycles → protocol_err pulses once; busy stays high for 76500 cycles; all cells read 0x20; AC=0.
- Write 0xD5 → AC=0 (out of range). Data read (rs=1, rw=1) at AC=3 holding 0x33 → lcd_data_oe high only while e is high, DB=0x33, AC=4 afterwards.
- Assert reset during CLEAR_FILL → all outputs return to reset values and INIT_FILL reruns; a 1-cycle E pulse afterwards is still captured.
